// File: rtl/l2_port_scheduler.sv
// l2_port_scheduler
//   Shares the single 256-bit L2 request port among the L1 icache, the L1
//   dcache and the next-line prefetcher. It uses fixed priority
//   dcache > icache > prefetch, with an icache starvation guard. Exactly one
//   transaction is outstanding at a time, and it is never preempted.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   ic_read/ic_addr         icache line read request (held until ic_resp)
//   dc_read/dc_write        dcache read / writeback request (held until dc_resp)
//   dc_addr/dc_wdata        dcache line address / writeback line
//   pf_read/pf_addr         prefetch read request (may drop before grant)
//   ic_resp/dc_resp/pf_resp one-cycle completion pulses
//   rdata                   L2 read line fanned out to all requesters
//   mem_read/mem_write      registered L2 port command
//   mem_addr/mem_wdata      registered L2 port address / write line
//   mem_resp/mem_rdata      L2 completion pulse / read line
//   grant                   current owner: 0 none, 1 icache, 2 dcache, 3 prefetch
//
// state | meaning
// IDLE  | arbitrate every cycle, issue the command on a grant
// BUSY  | command held stable, waiting for mem_resp
// DONE  | one bubble cycle so the completed requester can drop its request
module l2_port_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ic_read,
  input  logic [31:0]  ic_addr,
  output logic         ic_resp,
  input  logic         dc_read,
  input  logic         dc_write,
  input  logic [31:0]  dc_addr,
  input  logic [255:0] dc_wdata,
  output logic         dc_resp,
  input  logic         pf_read,
  input  logic [31:0]  pf_addr,
  output logic         pf_resp,
  output logic [255:0] rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [255:0] mem_wdata,
  input  logic         mem_resp,
  input  logic [255:0] mem_rdata,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IC   = 2'd1;
  localparam logic [1:0] OWN_DC   = 2'd2;
  localparam logic [1:0] OWN_PF   = 2'd3;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [1:0] pick;

  // The starvation override wins over the normal priority order.
  always_comb begin
    pick = OWN_NONE;
    if (ic_read && (starve_cnt == LIMIT)) pick = OWN_IC;
    else if (dc_read || dc_write)         pick = OWN_DC;
    else if (ic_read)                     pick = OWN_IC;
    else if (pf_read)                     pick = OWN_PF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= OWN_NONE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != OWN_NONE) begin
            grant <= pick;
            state <= BUSY;
            case (pick)
              OWN_IC: begin
                mem_addr   <= ic_addr;
                mem_read   <= 1'b1;
                mem_write  <= 1'b0;
                starve_cnt <= '0;
              end
              OWN_DC: begin
                // An illegal read+write request is issued as a writeback.
                mem_addr  <= dc_addr;
                mem_write <= dc_write;
                mem_read  <= ~dc_write;
                if (dc_write) mem_wdata <= dc_wdata;
                if (ic_read && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 4'd1;
              end
              OWN_PF: begin
                mem_addr  <= pf_addr;
                mem_read  <= 1'b1;
                mem_write <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            grant     <= OWN_NONE;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The completion pulse follows mem_resp in the same cycle, but only in BUSY.
  assign ic_resp = (state == BUSY) && mem_resp && (grant == OWN_IC);
  assign dc_resp = (state == BUSY) && mem_resp && (grant == OWN_DC);
  assign pf_resp = (state == BUSY) && mem_resp && (grant == OWN_PF);
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_l2_port_scheduler.sv
module tb_l2_port_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ic_read, dc_read, dc_write, pf_read;
  logic [31:0]  ic_addr, dc_addr, pf_addr;
  logic [255:0] dc_wdata;
  logic         ic_resp, dc_resp, pf_resp;
  logic [255:0] rdata;
  logic         mem_read, mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;
  logic [1:0]   grant;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t1, t2;

  l2_port_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_resp(ic_resp),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_resp(dc_resp),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_resp(pf_resp),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         ic, dr, dw, pf;
    logic [31:0]  ia, da, pa;
    logic [255:0] wd;
    logic [1:0]   eg;
    logic         er, ew;
    logic [31:0]  ea;
    logic         cw;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clear_reqs();
    ic_read = 0; dc_read = 0; dc_write = 0; pf_read = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_reqs();
    mem_resp = 0;
    tick();
    tick();
    reset_n = 1;
    tick();
  endtask

  // Starts in the first BUSY cycle; L2 responds lat cycles later. Ends in DONE.
  task automatic serve(input int lat, input logic [1:0] own);
    logic [255:0] rd;
    rd = {8{24'hA5A5A5, 6'd0, own}};
    repeat (lat) tick();
    mem_rdata = rd;
    mem_resp = 1;
    #1;
    check("ic_resp", ic_resp, own == 2'd1);
    check("dc_resp", dc_resp, own == 2'd2);
    check("pf_resp", pf_resp, own == 2'd3);
    check("rdata", rdata, rd);
    tick();
    mem_resp = 0;
    #1;
    check("done_grant", grant, 2'd0);
    check("done_mem_read", mem_read, 1'b0);
    check("done_mem_write", mem_write, 1'b0);
    check("done_resp", {ic_resp, dc_resp, pf_resp}, 3'b000);
  endtask

  initial begin
    reset_n = 0;
    clear_reqs();
    ic_addr = 0; dc_addr = 0; pf_addr = 0; dc_wdata = 0;
    mem_resp = 0; mem_rdata = 0;

    vecs[0] = '{1,0,0,0, 32'h40, 32'h0, 32'h0, 256'h0, 2'd1, 1,0, 32'h40, 0};
    vecs[1] = '{1,1,0,1, 32'h100, 32'h200, 32'h300, 256'h0, 2'd2, 1,0, 32'h200, 0};
    vecs[2] = '{1,0,0,1, 32'h100, 32'h0, 32'h300, 256'h0, 2'd1, 1,0, 32'h100, 0};
    vecs[3] = '{0,0,0,1, 32'h0, 32'h0, 32'h300, 256'h0, 2'd3, 1,0, 32'h300, 0};
    vecs[4] = '{0,0,1,0, 32'h0, 32'h8000_0020, 32'h0, {8{32'hDEADBEEF}}, 2'd2, 0,1, 32'h8000_0020, 1};
    vecs[5] = '{0,1,1,0, 32'h0, 32'h44, 32'h0, {8{32'h1234_5678}}, 2'd2, 0,1, 32'h44, 1};
    vecs[6] = '{0,1,0,1, 32'h0, 32'h280, 32'h380, 256'h0, 2'd2, 1,0, 32'h280, 0};

    do_reset();
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 256'h0);
    check("rst_grant", grant, 2'd0);

    // Stray mem_resp in IDLE produces no completion pulse.
    mem_resp = 1;
    #1;
    check("stray_resp", {ic_resp, dc_resp, pf_resp}, 3'b000);
    tick();
    mem_resp = 0;

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      ic_read = vecs[i].ic; dc_read = vecs[i].dr; dc_write = vecs[i].dw; pf_read = vecs[i].pf;
      ic_addr = vecs[i].ia; dc_addr = vecs[i].da; pf_addr = vecs[i].pa; dc_wdata = vecs[i].wd;
      tick();
      check($sformatf("v%0d_grant", i), grant, vecs[i].eg);
      check($sformatf("v%0d_mem_read", i), mem_read, vecs[i].er);
      check($sformatf("v%0d_mem_write", i), mem_write, vecs[i].ew);
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ea);
      if (vecs[i].cw) check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wd);
      clear_reqs();
      serve(2, vecs[i].eg);
      tick();
    end

    // Priority: all three held, each drops after its own completion.
    do_reset();
    ic_addr = 32'h100; dc_addr = 32'h200; pf_addr = 32'h300;
    ic_read = 1; dc_read = 1; pf_read = 1;
    tick();
    check("prio1_grant", grant, 2'd2);
    check("prio1_addr", mem_addr, 32'h200);
    serve(1, 2'd2);
    dc_read = 0;
    tick();
    tick();
    check("prio2_grant", grant, 2'd1);
    check("prio2_addr", mem_addr, 32'h100);
    serve(1, 2'd1);
    ic_read = 0;
    tick();
    tick();
    check("prio3_grant", grant, 2'd3);
    check("prio3_addr", mem_addr, 32'h300);
    serve(1, 2'd3);
    pf_read = 0;
    tick();

    // Starvation: dcache requests back-to-back while icache waits.
    do_reset();
    ic_addr = 32'h100; dc_addr = 32'h200;
    ic_read = 1; dc_read = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("starve%0d_grant", k), grant, (k < 4) ? 2'd2 : 2'd1);
      serve(1, (k < 4) ? 2'd2 : 2'd1);
      tick();
    end
    check("starve_cnt_cleared", dut.starve_cnt, 4'd0);
    tick();
    check("starve_after_grant", grant, 2'd2);
    clear_reqs();
    serve(1, 2'd2);
    tick();

    // Prefetch pulse during a dcache transaction is never granted.
    dc_read = 1; dc_addr = 32'h600;
    tick();
    dc_read = 0;
    pf_read = 1; pf_addr = 32'h700;
    tick();
    pf_read = 0;
    serve(1, 2'd2);
    tick();
    tick();
    check("pfdrop_grant", grant, 2'd0);
    check("pfdrop_mem_read", mem_read, 1'b0);

    // Prefetch dropped during its own BUSY still completes.
    pf_read = 1; pf_addr = 32'h740;
    tick();
    check("pfown_grant", grant, 2'd3);
    pf_read = 0;
    serve(2, 2'd3);
    tick();

    // Latency: 10-cycle L2, back-to-back icache requests.
    ic_read = 1; ic_addr = 32'h900;
    tick();
    check("lat1_mem_read", mem_read, 1'b1);
    t1 = cyc;
    serve(10, 2'd1);
    tick();
    check("lat_idle_mem_read", mem_read, 1'b0);
    tick();
    check("lat2_mem_read", mem_read, 1'b1);
    t2 = cyc;
    check("lat_spacing", 32'(t2 - t1), 32'd13);
    ic_read = 0;
    serve(10, 2'd1);
    tick();

    // Reset asserted in the middle of a writeback.
    dc_write = 1; dc_addr = 32'h8000_0040; dc_wdata = {8{32'hCAFEF00D}};
    tick();
    check("mid_mem_write", mem_write, 1'b1);
    tick();
    reset_n = 0;
    #1;
    check("arst_mem_write", mem_write, 1'b0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_wdata", mem_wdata, 256'h0);
    check("arst_grant", grant, 2'd0);
    mem_resp = 1;
    #1;
    check("arst_resp", {ic_resp, dc_resp, pf_resp}, 3'b000);
    mem_resp = 0;
    clear_reqs();
    tick();
    reset_n = 1;
    tick();
    ic_read = 1; ic_addr = 32'h0000_0040;
    tick();
    check("post_rst_mem_read", mem_read, 1'b1);
    check("post_rst_mem_addr", mem_addr, 32'h40);
    ic_read = 0;
    serve(1, 2'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
